// File: rtl/hex_display_ctrl.sv
// N-digit seven-segment controller on an Avalon-MM slave: per-digit raw/hex decode, blink, dp, global enable/blank.
// Define HEX_DISPLAY_BCD_EN to build the iterative double-dabble binary-to-BCD loader at address 0xD.
module hex_display_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int CLK_HZ     = 50_000_000,
    parameter int BLINK_HZ   = 2,
    parameter int ACTIVE_LOW = 1,
    parameter int BIN_W      = 20
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              avs_address,
    input  logic                    avs_write,
    input  logic [31:0]             avs_writedata,
    input  logic                    avs_read,
    output logic [31:0]             avs_readdata,
    output logic [NUM_DIGITS*8-1:0] hex_out
);

    localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int PW        = $clog2(BLINK_DIV) + 1;
    localparam logic [7:0] SEG_OFF = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    logic [10:0]             r_digit [NUM_DIGITS];
    logic [10:0]             w_digit_nxt [NUM_DIGITS];
    logic [1:0]              r_ctrl;
    logic [PW-1:0]           r_presc;
    logic                    r_phase;
    logic [31:0]             r_readdata;
    logic [31:0]             w_rdata;
    logic [NUM_DIGITS*8-1:0] r_hex;
    logic [NUM_DIGITS*8-1:0] w_hex;
    logic [7:0]              w_pat [NUM_DIGITS];
    logic                    w_busy;
    logic                    w_ovf;
    logic                    w_done;
    logic [4*NUM_DIGITS-1:0] w_bcd_nib;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Free-running blink prescaler; phase is shared by every digit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_phase <= 1'b0;
        end else if (r_presc == PW'(BLINK_DIV - 1)) begin
            r_presc <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

`ifdef HEX_DISPLAY_BCD_EN
    // One spare BCD digit above NUM_DIGITS always exists so overflow is visible.
    localparam int BCD_DIGITS = (BIN_W / 3 + 1 > NUM_DIGITS) ? BIN_W / 3 + 1 : NUM_DIGITS + 1;
    localparam int CW         = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} bcd_state_t;

    bcd_state_t              r_state;
    bcd_state_t              w_state_nxt;
    logic [BIN_W-1:0]        r_bin;
    logic [4*BCD_DIGITS-1:0] r_bcd;
    logic [4*BCD_DIGITS-1:0] w_bcd_adj;
    logic [CW-1:0]           r_cnt;
    logic                    r_ovf;
    logic                    w_load;
    logic                    w_unused;

    assign w_busy    = (r_state != S_IDLE);
    assign w_done    = (r_state == S_DONE);
    assign w_load    = avs_write && (avs_address == 4'hD) && !w_busy;
    assign w_ovf     = r_ovf;
    assign w_bcd_nib = r_bcd[4*NUM_DIGITS-1:0];
    assign w_unused  = &{1'b0, avs_writedata, w_bcd_adj[4*BCD_DIGITS-1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_load) w_state_nxt = S_SHIFT;
            S_SHIFT: if (r_cnt == CW'(BIN_W - 1)) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_load) begin
            r_bin <= avs_writedata[BIN_W-1:0];
            r_bcd <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (r_state == S_SHIFT) begin
            {r_bcd, r_bin} <= {w_bcd_adj[4*BCD_DIGITS-2:0], r_bin, 1'b0};
            r_cnt          <= r_cnt + 1'b1;
        end else if (w_done) begin
            r_ovf <= |r_bcd[4*BCD_DIGITS-1:4*NUM_DIGITS];
        end
    end
`else
    localparam int BIN_W_UNUSED = BIN_W;
    logic w_unused;

    assign w_busy    = 1'b0;
    assign w_done    = 1'b0;
    assign w_ovf     = 1'b0;
    assign w_bcd_nib = '0;
    assign w_unused  = &{1'b0, avs_writedata};
`endif

    // A completing conversion overrides nibble/decode after any same-edge CPU write.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_digit_nxt[i] = r_digit[i];
            if (avs_write && (avs_address == 4'(i))) w_digit_nxt[i] = avs_writedata[10:0];
            if (w_done) w_digit_nxt[i] = {w_digit_nxt[i][10:9], 1'b1, 4'h0, w_bcd_nib[4*i +: 4]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) r_digit[i] <= '0;
            r_ctrl <= 2'b01;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) r_digit[i] <= w_digit_nxt[i];
            if (avs_write && (avs_address == 4'hF)) r_ctrl <= avs_writedata[1:0];
        end
    end

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (avs_address == 4'(i)) w_rdata[10:0] = r_digit[i];
        end
        if (avs_address == 4'hE) w_rdata[2:0] = {w_ovf, w_busy, r_phase};
        if (avs_address == 4'hF) w_rdata[1:0] = r_ctrl;
    end

    always_comb begin
        w_hex = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_pat[i] = r_digit[i][8] ? {r_digit[i][10], seg7(r_digit[i][3:0])} : r_digit[i][7:0];
            if (!r_ctrl[0] || r_ctrl[1] || (r_digit[i][9] && r_phase)) w_pat[i] = 8'h00;
            w_hex[8*i +: 8] = (ACTIVE_LOW != 0) ? ~w_pat[i] : w_pat[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata <= '0;
            r_hex      <= {NUM_DIGITS{SEG_OFF}};
        end else begin
            if (avs_read) r_readdata <= w_rdata;
            r_hex <= w_hex;
        end
    end

    assign avs_readdata = r_readdata;
    assign hex_out      = r_hex;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Scoreboard bench for hex_display_ctrl: a cycle-level behavioural model queues expected hex_out and read data;
// a negedge monitor pops and compares. BCD loader checks are enabled with HEX_DISPLAY_BCD_EN.
module tb_hex_display_ctrl;

  localparam int ND       = 6;
  localparam int CLK_HZ   = 100;
  localparam int BLINK_HZ = 5;
  localparam int DIV      = CLK_HZ / (2 * BLINK_HZ);
  localparam int BIN_W    = 20;
  localparam logic [ND*8-1:0] ALL_OFF = {ND{8'hFF}};

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [3:0]        avs_address = '0;
  logic              avs_write = 1'b0;
  logic [31:0]       avs_writedata = '0;
  logic              avs_read = 1'b0;
  logic [31:0]       avs_readdata;
  logic [ND*8-1:0]   hex_out;

  hex_display_ctrl #(
    .NUM_DIGITS(ND), .CLK_HZ(CLK_HZ), .BLINK_HZ(BLINK_HZ), .ACTIVE_LOW(1), .BIN_W(BIN_W)
  ) dut (
    .clk(clk), .reset(reset), .avs_address(avs_address), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_read(avs_read), .avs_readdata(avs_readdata),
    .hex_out(hex_out)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard state
  logic [ND*8-1:0] exp_hex_q[$];
  logic [31:0]     exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  bit rd_done = 0;

  // Behavioural model
  logic [6:0]  seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [10:0] m_digit [ND];
  logic [1:0]  m_ctrl;
  longint      m_edges;
  bit          m_busy, m_ovf;
  int          m_left;
  longint      m_val;

  function automatic bit m_phase();
    return ((m_edges / DIV) % 2) == 1;
  endfunction

  function automatic logic [ND*8-1:0] model_hex();
    logic [ND*8-1:0] r;
    logic [10:0] d;
    logic [7:0] p;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      d = m_digit[i];
      p = d[8] ? {d[10], seg_tab[d[3:0]]} : d[7:0];
      if (!m_ctrl[0] || m_ctrl[1] || (d[9] && m_phase())) p = 8'h00;
      r[8*i +: 8] = ~p;
    end
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] a);
    logic [31:0] v;
    v = '0;
    if (int'(a) < ND) v = {21'b0, m_digit[a]};
    else if (a == 4'hE) v = {29'b0, m_ovf, m_busy, m_phase()};
    else if (a == 4'hF) v = {30'b0, m_ctrl};
    return v;
  endfunction

  always @(posedge clk) begin
    bit busy_pre;
    if (reset) begin
      exp_hex_q.push_back(ALL_OFF);
      for (int i = 0; i < ND; i++) m_digit[i] = '0;
      m_ctrl = 2'b01; m_edges = 0; m_busy = 0; m_ovf = 0; m_left = 0; m_val = 0;
      rd_done = 0;
    end else begin
      exp_hex_q.push_back(model_hex());
      rd_done = avs_read;
      if (avs_read) exp_q.push_back(model_read(avs_address));
      busy_pre = m_busy;
      if (avs_write) begin
        if (int'(avs_address) < ND) m_digit[avs_address] = avs_writedata[10:0];
        if (avs_address == 4'hF) m_ctrl = avs_writedata[1:0];
`ifdef HEX_DISPLAY_BCD_EN
        if (avs_address == 4'hD && !busy_pre) begin
          m_val = longint'(avs_writedata) % (longint'(1) << BIN_W);
          m_busy = 1; m_left = BIN_W + 1; m_ovf = 0;
        end
`endif
      end
      if (busy_pre) begin
        m_left--;
        if (m_left == 0) begin
          for (int i = 0; i < ND; i++)
            m_digit[i] = {m_digit[i][10:9], 1'b1, 4'h0, 4'((m_val / (10 ** i)) % 10)};
          m_ovf = m_val > (10 ** ND) - 1;
          m_busy = 0;
        end
      end
      m_edges++;
    end
  end

  // Monitor
  always @(negedge clk) begin
    logic [ND*8-1:0] eh;
    logic [31:0] er;
    if (exp_hex_q.size() > 0) begin
      eh = exp_hex_q.pop_front();
      n_checks++;
      if (hex_out !== eh) begin
        n_errors++;
        $display("FAIL hex_out @%0t: got %h expected %h", $time, hex_out, eh);
      end
    end
    if (rd_done) begin
      rd_done = 0;
      if (exp_q.size() > 0) begin
        er = exp_q.pop_front();
        n_checks++;
        if (avs_readdata !== er) begin
          n_errors++;
          $display("FAIL readdata @%0t: got %h expected %h", $time, avs_readdata, er);
        end
      end
    end
  end

  // Driver tasks
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk); #1;
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(posedge clk); #1;
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    @(negedge clk); #1;
    avs_address = a; avs_read = 1'b1;
    @(posedge clk); #1;
    avs_read = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk); #1;
    reset = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] a;
    logic [31:0] d;
    int op;
    idle(3);
    #1;
    n_checks++;
    if (avs_readdata !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_readdata: got %h expected 00000000", avs_readdata);
    end
    @(negedge clk); #1;
    reset = 1'b0;
    rd(4'hF);
    wr(4'h0, 32'h105);
    idle(3);
    rd(4'h0);
    wr(4'h1, 32'h208);
    idle(45);
    wr(4'hF, 32'h3);
    idle(3);
    wr(4'hF, 32'h1);
    idle(3);
    wr(4'h9, 32'h55);
    rd(4'h9);
    rd(4'h1);
`ifdef HEX_DISPLAY_BCD_EN
    wr(4'hD, 32'd123456);
    idle(2);
    rd(4'hE);
    wr(4'hD, 32'd999);
    idle(20);
    rd(4'hE);
    for (int i = 0; i < ND; i++) rd(4'(i));
    wr(4'hD, 32'd1000000);
    idle(24);
    rd(4'hE);
    rd(4'h0);
    wr(4'hD, 32'd777);
    idle(5);
    do_reset(2);
    rd(4'hE);
    rd(4'h2);
    wr(4'hD, 32'd42);
    idle(24);
    rd(4'hE);
    rd(4'h0);
    rd(4'h1);
`endif
    for (int k = 0; k < 400; k++) begin
      op = $urandom_range(0, 9);
      a  = 4'($urandom_range(0, 15));
      d  = $urandom;
      if (a == 4'hF && $urandom_range(0, 3) != 0) d = 32'h1;
      if (op < 4) wr(a, d);
      else if (op < 8) rd(a);
      else idle($urandom_range(1, 12));
    end
    idle(4);
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL read_drain: %0d expected reads never compared", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
